// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control unit for a multicycle RV32I datapath that shares one memory for
//   instructions and data. A Moore FSM steps the datapath (PC, OldPC, IR,
//   ALUOut, Data) through one micro-step per cycle. It waits on a
//   wait-stated memory handshake and falls into a sticky FAULT state on a
//   memory timeout.
//
//   Handshake: in FETCH, MEMREAD and MEMWRITE, mem_req is valid and
//   mem_ready is the memory's ready. A transfer completes on any cycle where
//   both are high, including the cycle the state is entered. The FSM holds
//   the state while mem_ready is low. When mem_ready has stayed low for
//   TIMEOUT held cycles, the next low cycle moves the FSM to FAULT and
//   commits no strobe.
//
//   Optional feature: define ILLEGAL_TRAP_EN to trap unsupported opcodes in
//   DECODE. The trap sets illegal and fault and enters FAULT. With the macro
//   undefined, an unsupported opcode behaves as a NOP and illegal is tied 0.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   op, funct3            IR[6:0] and IR[14:12]
//   zero                  ALU zero flag, used for bne/beq
//   mem_ready             memory accepts/returns data this cycle
//   mem_req               memory access request
//   AdrSrc                memory address select: 0 PC, 1 ALUOut
//   MemWrite              store strobe
//   IRWrite               IR/OldPC load
//   PCWrite               PC load
//   RegWrite              register file write
//   ResultSrc             result select: 00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA               ALU A select: 00 PC, 01 OldPC, 10 rs1, 11 zero
//   ALUSrcB               ALU B select: 00 rs2, 01 imm, 10 const 4
//   ALUOp                 ALU op class: 00 add, 01 sub/compare, 10 funct
//   ImmSrc                immediate format from op: I, S, B, J, U
//   state_o               current FSM state (debug)
//   fault                 sticky fault flag
//   illegal               sticky illegal-opcode flag
module multicycle_controller #(
  parameter int STATE_W    = 4,
  parameter int WAIT_CNT_W = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [2:0]         ImmSrc,
  output logic [STATE_W-1:0] state_o,
  output logic               fault,
  output logic               illegal
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9),
    JAL      = STATE_W'(10),
    JALR     = STATE_W'(11),
    LINK     = STATE_W'(12),
    LUI      = STATE_W'(13),
    AUIPC    = STATE_W'(14),
    FAULT    = STATE_W'(15)
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0] CNT_MAX     = '1;

  state_t                state;
  state_t                decodeNext;
  logic [WAIT_CNT_W-1:0] waitCnt;
  logic                  faultReg;
  logic                  memPhase;
  logic                  timeoutHit;
  logic                  branchTaken;
`ifdef ILLEGAL_TRAP_EN
  logic                  illegalReg;
  logic                  opKnown;
`endif

  assign memPhase    = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  // A ready cycle always completes the access, even at the timeout count.
  assign timeoutHit  = memPhase && !mem_ready && (waitCnt == TIMEOUT_CNT);
  // Only beq and bne are branches here; other funct3 codes fall through.
  assign branchTaken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

  always_comb begin
    decodeNext = FETCH;
    case (op)
      OP_LW, OP_SW: decodeNext = MEMADR;
      OP_R:         decodeNext = EXECR;
      OP_I:         decodeNext = EXECI;
      OP_BRANCH:    decodeNext = BRANCH;
      OP_JAL:       decodeNext = JAL;
      OP_JALR:      decodeNext = JALR;
      OP_LUI:       decodeNext = LUI;
      OP_AUIPC:     decodeNext = AUIPC;
      OP_NOP:       decodeNext = FETCH;
`ifdef ILLEGAL_TRAP_EN
      default:      decodeNext = FAULT;
`else
      default:      decodeNext = FETCH;
`endif
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign opKnown = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
                   (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR) ||
                   (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_NOP);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      waitCnt  <= '0;
      faultReg <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegalReg <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH, MEMREAD, MEMWRITE: begin
          if (mem_ready) begin
            waitCnt <= '0;
            if (state == FETCH)        state <= DECODE;
            else if (state == MEMREAD) state <= MEMWB;
            else                       state <= FETCH;
          end else if (timeoutHit) begin
            waitCnt  <= '0;
            state    <= FAULT;
            faultReg <= 1'b1;
          end else if (waitCnt != CNT_MAX) begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        DECODE: begin
          state <= decodeNext;
`ifdef ILLEGAL_TRAP_EN
          if (!opKnown) begin
            faultReg   <= 1'b1;
            illegalReg <= 1'b1;
          end
`endif
        end
        MEMADR: begin
          if (op == OP_LW) state <= MEMREAD;
          else             state <= MEMWRITE;
        end
        MEMWB, ALUWB, BRANCH:                 state <= FETCH;
        EXECR, EXECI, JAL, LINK, LUI, AUIPC:  state <= ALUWB;
        JALR:                                 state <= LINK;
        FAULT:                                state <= FAULT;
        default:                              state <= FAULT;
      endcase
    end
  end

  // Moore decode of the registered state. The strobes that depend on the
  // handshake are qualified by mem_ready or by timeoutHit; reset clears
  // every output.
  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_req   = !timeoutHit;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        MEMREAD: begin
          mem_req = !timeoutHit;
          AdrSrc  = 1'b1;
        end
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          mem_req  = !timeoutHit;
          AdrSrc   = 1'b1;
          MemWrite = !timeoutHit;
        end
        EXECR: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        ALUWB: RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b01;
          PCWrite = branchTaken;
        end
        JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        JALR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        LINK: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        LUI: begin
          ALUSrcA = 2'b11;
          ALUSrcB = 2'b01;
        end
        AUIPC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ImmSrc = 3'b000;
    if (!reset) begin
      case (op)
        OP_SW:            ImmSrc = 3'b001;
        OP_BRANCH:        ImmSrc = 3'b010;
        OP_JAL:           ImmSrc = 3'b011;
        OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
        default:          ImmSrc = 3'b000;
      endcase
    end
  end

  assign state_o = state;
  assign fault   = faultReg;
`ifdef ILLEGAL_TRAP_EN
  assign illegal = illegalReg;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. The reference model expands each
// instruction into its sequence of micro-steps. Memory steps repeat for the
// chosen number of wait cycles. Every cycle is checked against the control
// word that the step table gives for that step.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [3:0] state_o;
  logic       fault, illegal;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .state_o(state_o),
    .fault(fault), .illegal(illegal)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
  localparam int S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9;
  localparam int S_JAL = 10, S_JALR = 11, S_LINK = 12, S_LUI = 13, S_AUIPC = 14, S_FAULT = 15;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_NOP = 7'b0000000, OP_BAD = 7'b1111111;

  int nChecks = 0;
  int nFail   = 0;
  int phases[$];

  // Control word: {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
  //                ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
  function automatic logic [13:0] got_ctrl();
    return {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
            ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  endfunction

  function automatic logic [13:0] exp_ctrl(input int p, input logic rdy,
                                           input logic [2:0] f3, input logic z);
    logic mr, as, mw, iw, pw, rw;
    logic [1:0] rs, sa, sb, ao;
    {mr, as, mw, iw, pw, rw} = '0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00;
    case (p)
      S_FETCH:    begin mr = 1; sb = 2'b10; rs = 2'b10; iw = rdy; pw = rdy; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      S_MEMREAD:  begin mr = 1; as = 1; end
      S_MEMWB:    begin rs = 2'b01; rw = 1; end
      S_MEMWRITE: begin mr = 1; as = 1; mw = 1; end
      S_EXECR:    begin sa = 2'b10; ao = 2'b10; end
      S_EXECI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      S_ALUWB:    rw = 1;
      S_BRANCH:   begin
        sa = 2'b10; ao = 2'b01;
        // beq takes on equal, bne on not-equal, anything else falls through
        pw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
      end
      S_JAL:      begin sa = 2'b01; sb = 2'b10; pw = 1; end
      S_JALR:     begin sa = 2'b10; sb = 2'b01; rs = 2'b10; pw = 1; end
      S_LINK:     begin sa = 2'b01; sb = 2'b10; end
      S_LUI:      begin sa = 2'b11; sb = 2'b01; end
      S_AUIPC:    begin sa = 2'b01; sb = 2'b01; end
      default: ;
    endcase
    return {mr, as, mw, iw, pw, rw, rs, sa, sb, ao};
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    if (o == OP_SW) return 3'b001;
    if (o == OP_BR) return 3'b010;
    if (o == OP_JAL) return 3'b011;
    if (o == OP_LUI || o == OP_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  task automatic build_phases(input logic [6:0] o);
    phases = {};
    phases.push_back(S_FETCH);
    phases.push_back(S_DECODE);
    case (o)
      OP_LW:    begin phases.push_back(S_MEMADR); phases.push_back(S_MEMREAD); phases.push_back(S_MEMWB); end
      OP_SW:    begin phases.push_back(S_MEMADR); phases.push_back(S_MEMWRITE); end
      OP_R:     begin phases.push_back(S_EXECR); phases.push_back(S_ALUWB); end
      OP_I:     begin phases.push_back(S_EXECI); phases.push_back(S_ALUWB); end
      OP_BR:    phases.push_back(S_BRANCH);
      OP_JAL:   begin phases.push_back(S_JAL); phases.push_back(S_ALUWB); end
      OP_JALR:  begin phases.push_back(S_JALR); phases.push_back(S_LINK); phases.push_back(S_ALUWB); end
      OP_LUI:   begin phases.push_back(S_LUI); phases.push_back(S_ALUWB); end
      OP_AUIPC: begin phases.push_back(S_AUIPC); phases.push_back(S_ALUWB); end
      OP_NOP:   ;
      default:  if (TRAP) phases.push_back(S_FAULT);
    endcase
  endtask

  // Runs one whole instruction from FETCH. fetchWait and memWait set how many
  // not-ready cycles come before the completing ready cycle.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                           input int fetchWait, input int memWait, input string tag);
    int p, w, n;
    bit isMem;
    logic rdy;
    logic [13:0] expC;
    build_phases(o);
    foreach (phases[i]) begin
      p = phases[i];
      isMem = (p == S_FETCH) || (p == S_MEMREAD) || (p == S_MEMWRITE);
      w = (p == S_FETCH) ? fetchWait : memWait;
      n = isMem ? w + 1 : 1;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        reset = 1'b0; op = o; funct3 = f3; zero = z;
        rdy = isMem ? (c == w) : 1'($urandom_range(0, 1));
        mem_ready = rdy;
        #1;
        nChecks++;
        if (state_o !== 4'(p)) begin
          nFail++;
          $display("FAIL %s state: got %0d expected %0d (cycle %0d)", tag, state_o, p, c);
        end
        expC = exp_ctrl(p, rdy, f3, z);
        nChecks++;
        if (got_ctrl() !== expC) begin
          nFail++;
          $display("FAIL %s ctrl in state %0d: got %b expected %b", tag, p, got_ctrl(), expC);
        end
        nChecks++;
        if (ImmSrc !== exp_imm(o)) begin
          nFail++;
          $display("FAIL %s ImmSrc: got %b expected %b", tag, ImmSrc, exp_imm(o));
        end
        nChecks++;
        if (fault !== (p == S_FAULT) || illegal !== (p == S_FAULT)) begin
          nFail++;
          $display("FAIL %s fault/illegal: got %b/%b expected %b/%b", tag, fault, illegal,
                   (p == S_FAULT), (p == S_FAULT));
        end
      end
    end
    if (phases[phases.size()-1] == S_FAULT) begin
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1; op = OP_SW; funct3 = 3'b000; zero = 1'b0;
    @(negedge clk);
    #1;
    nChecks++;
    if (state_o !== 4'd0 || fault !== 1'b0 || illegal !== 1'b0) begin
      nFail++;
      $display("FAIL reset_state: got state %0d fault %b illegal %b expected 0 0 0", state_o, fault, illegal);
    end
    nChecks++;
    if (got_ctrl() !== 14'd0 || ImmSrc !== 3'd0) begin
      nFail++;
      $display("FAIL reset_outputs: got ctrl %b imm %b expected all 0", got_ctrl(), ImmSrc);
    end
  endtask

  task automatic test_r_type();
    run_instr(OP_R, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, 0, "r_type");
  endtask

  task automatic test_lw_wait();
    run_instr(OP_LW, 3'b010, 1'b0, 0, 3, "lw_wait3");
    // A full 15-cycle fetch wait only survives if the counter was cleared.
    run_instr(OP_R, 3'b000, 1'b0, 15, 0, "after_lw_cnt_clear");
  endtask

  task automatic test_sw();
    run_instr(OP_SW, 3'b010, 1'b0, 1, 2, "sw");
    run_instr(OP_SW, 3'b010, 1'b1, 0, 0, "sw_zero_wait");
  endtask

  task automatic test_branch();
    run_instr(OP_BR, 3'b000, 1'b1, 0, 0, "beq_taken");
    run_instr(OP_BR, 3'b001, 1'b1, 0, 0, "bne_not_taken");
    run_instr(OP_BR, 3'b000, 1'b0, 0, 0, "beq_not_taken");
    run_instr(OP_BR, 3'b001, 1'b0, 0, 0, "bne_taken");
    run_instr(OP_BR, 3'b100, 1'b1, 0, 0, "blt_f3_z1");
    run_instr(OP_BR, 3'b101, 1'b0, 0, 0, "bge_f3_z0");
  endtask

  task automatic test_jalr();
    run_instr(OP_JALR, 3'b000, 1'b0, 2, 0, "jalr");
  endtask

  task automatic test_jal_lui_auipc();
    run_instr(OP_JAL, 3'b000, 1'b0, 0, 0, "jal");
    run_instr(OP_LUI, 3'b000, 1'b0, 0, 0, "lui");
    run_instr(OP_AUIPC, 3'b000, 1'b0, 0, 0, "auipc");
    run_instr(OP_I, 3'b000, 1'b0, 0, 0, "addi");
    run_instr(OP_NOP, 3'b000, 1'b0, 0, 0, "nop");
  endtask

  task automatic test_ready_wins();
    run_instr(OP_LW, 3'b010, 1'b0, 15, 15, "lw_ready_at_timeout");
    run_instr(OP_SW, 3'b010, 1'b0, 0, 15, "sw_ready_at_timeout");
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      reset = 1'b0; op = OP_LW; mem_ready = 1'b0;
      #1;
      nChecks++;
      if (state_o !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0 || mem_req !== (c < 15)) begin
        nFail++;
        $display("FAIL timeout_fetch c=%0d: got state %0d IRWrite %b PCWrite %b mem_req %b expected 0 0 0 %b",
                 c, state_o, IRWrite, PCWrite, mem_req, (c < 15));
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      nChecks++;
      if (state_o !== 4'd15 || fault !== 1'b1 || got_ctrl() !== 14'd0) begin
        nFail++;
        $display("FAIL fault_state c=%0d: got state %0d fault %b ctrl %b expected 15 1 0",
                 c, state_o, fault, got_ctrl());
      end
    end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    nChecks++;
    if (got_ctrl() !== 14'd0) begin
      nFail++;
      $display("FAIL fault_reset_strobes: got %b expected 0", got_ctrl());
    end
    @(negedge clk);
    #1;
    nChecks++;
    if (state_o !== 4'd0 || fault !== 1'b0) begin
      nFail++;
      $display("FAIL fault_cleared: got state %0d fault %b expected 0 0", state_o, fault);
    end
  endtask

  task automatic test_reset_mid_access();
    int expS[4] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      reset = 1'b0; op = OP_LW; funct3 = 3'b010;
      mem_ready = (c == 0);
      #1;
      nChecks++;
      if (state_o !== 4'(expS[c < 4 ? c : 3])) begin
        nFail++;
        $display("FAIL mid_access_state c=%0d: got %0d expected %0d", c, state_o, expS[c < 4 ? c : 3]);
      end
    end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    nChecks++;
    if (got_ctrl() !== 14'd0 || state_o !== 4'd3) begin
      nFail++;
      $display("FAIL mid_access_reset_cycle: got ctrl %b state %0d expected 0 3", got_ctrl(), state_o);
    end
    @(negedge clk);
    #1;
    nChecks++;
    if (state_o !== 4'd0) begin
      nFail++;
      $display("FAIL mid_access_after_reset: got state %0d expected 0", state_o);
    end
  endtask

  task automatic test_illegal();
    run_instr(OP_BAD, 3'b000, 1'b0, 0, 0, "illegal_op");
    run_instr(OP_R, 3'b000, 1'b0, 0, 0, "after_illegal");
  endtask

  task automatic test_random();
    logic [6:0] opList[13] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR,
                               OP_LUI, OP_AUIPC, OP_NOP, OP_BAD, 7'b0001111, 7'b1110011};
    for (int k = 0; k < 150; k++) begin
      run_instr(opList[$urandom_range(0, 12)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4), "random");
    end
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jalr();
    test_jal_lui_auipc();
    test_ready_wins();
    test_timeout();
    test_reset_mid_access();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
